fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program-counter and fetch stage that sits directly upstream of instruction memory.
- Drives the memory's word-indexed read address and captures the combinational instruction word it returns.
- Buffers fetched {pc, instruction} pairs in a small in-order FIFO and presents them to decode over a valid/ready handshake.
- Supports branch/jump redirects (flush plus PC reload) and flags fetches beyond the 64 KB instruction space.

Parameters:
- RESET_PC, 32'h0000_0000: byte address fetched first after reset; must be word aligned.
- DEPTH, 2: fetch FIFO entries; must be at least 2.
- MEM_WORDS, 16384: instruction memory size in 32-bit words; word indices at or above this value fault.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- redirectValid  in  1  branch/jump taken this cycle.
- redirectTarget  in  32  byte address of the new fetch stream.
- imemAddr  out  32  word index to instruction memory: {2'b00, pc[31:2]}.
- imemData  in  32  instruction word returned combinationally for imemAddr.
- outValid  out  1  head FIFO entry valid toward decode.
- outReady  in  1  decode accepts the head entry.
- outInstr  out  32  head entry instruction.
- outPc  out  32  head entry byte PC.
- fetchFault  out  1  sticky flag: fetch attempted at word index >= MEM_WORDS.

Behaviour:
- Reset, asynchronous and active-low:
  - pc = RESET_PC, count = 0, faulted = 0.
  - All FIFO storage is cleared to 0.
  - outValid = 0, outInstr = 0, outPc = 0, fetchFault = 0, imemAddr = RESET_PC >> 2.
  - Reset asserted mid-stream discards all buffered entries immediately.
- imemAddr is purely combinational from the pc register. The low two bits of pc are always 00.
- pop = outValid && outReady.
- outValid = (count != 0) && !redirectValid. outInstr and outPc show the head entry (0 when empty).
- inRange = (pc[31:2] < MEM_WORDS).
- fire = !redirectValid && !faulted && inRange && (count < DEPTH || pop).
- On fire:
  - Push {pc, imemData} at the FIFO tail.
  - pc <= pc + 4 (mod 2^32).
- Stall when FIFO is full and there is no pop: pc holds, so imemAddr holds. imemData is re-sampled only when the push eventually fires.
- Simultaneous push and pop: count is unchanged. This sustains a throughput of 1 instruction per cycle.
- Fault:
  - If !redirectValid && !faulted && !inRange && space is available, set faulted <= 1 and do not push. pc holds.
  - fetchFault = faulted.
  - Entries already buffered still drain normally.
- Redirect has the highest priority:
  - FIFO is flushed: count <= 0, head/tail pointers reset.
  - pc <= {redirectTarget[31:2], 2'b00}; the low two target bits are silently dropped.
  - faulted <= 0.
  - No push that cycle. outValid is forced low that cycle, so no handshake completes.
- Redirect held for several cycles: each cycle reloads pc and nothing is fetched.
- Latency:
  - A push in cycle N makes the entry visible at outValid in cycle N+1 (first fetch after reset release: outValid high one cycle later).
  - After a redirect in cycle N: fetch at the target in cycle N+1, outValid in cycle N+2.
- Ordering: strictly in fetch order, with no duplicates and no drops except on flush.
- Pointer wrap: FIFO pointers wrap modulo DEPTH. count ranges 0..DEPTH.

Test Plan:
- Stream: memory word i = 32'hA000_0000+i, outReady=1 from reset release -> outValid from 2nd cycle; outPc 0,4,8,12 on consecutive cycles; outInstr A0000000, A0000001, ...
- Backpressure: outReady=0 for 5 cycles -> count saturates at 2 (pc 0, 4 buffered); imemAddr holds at 2. Then outReady=1 -> pcs 0,4,8 in order with no gap or duplicate.
- Redirect: pulse redirectValid with redirectTarget=32'h0000_0103 while FIFO full -> outValid low that cycle, FIFO empties, next fetch imemAddr=0x40, first delivered outPc=32'h100 two cycles later.
- Fault: redirect to 32'h0000_FFFC, outReady=1 -> instruction at pc FFFC delivered; next cycle fetchFault=1, outValid drops after drain, imemAddr stays 0x4000. Then redirect to 0 -> fetchFault=0, streaming resumes.
- Reset mid-operation: assert rst_n=0 asynchronously with 2 buffered entries -> outValid, outPc, outInstr, fetchFault all 0 immediately, with no clock edge needed. On release, fetch restarts at RESET_PC.
- Full with simultaneous push/pop: FIFO full, outReady=1 for 4 cycles -> count stays 2 and outPc increments by 4 every cycle.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit bundle: redirect input, instruction-memory address/data, decode handshake, fault flag.
// master: the fetch unit (drives imemAddr, out*, fetchFault); slave: memory/decode/branch side.
// Pure wiring, no state; clk/rst_n stay scalar ports on the modules.
interface fetch_unit_if;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInstr;
  logic [31:0] outPc;
  logic        fetchFault;

  modport master (
    input  redirectValid, redirectTarget, imemData, outReady,
    output imemAddr, outValid, outInstr, outPc, fetchFault
  );

  modport slave (
    output redirectValid, redirectTarget, imemData, outReady,
    input  imemAddr, outValid, outInstr, outPc, fetchFault
  );
endinterface

// File: rtl/fetch_unit.sv
// PC + fetch stage: drives word-indexed imem address, buffers {pc, instr} in an in-order FIFO for decode.
// Latency: push in cycle N visible at outValid in N+1; redirect in N -> fetch at target N+1, valid N+2.
// Backpressure: full FIFO without a pop holds pc (imemAddr stable); redirect flushes and masks outValid.
// Ports: clk, rst_n (async active-low), bus (fetch_unit_if.master: redirect, imem, decode handshake, fault).
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter int          MEM_WORDS = 16384
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int               PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W       = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(DEPTH - 1);
  localparam logic [31:0]      MEM_WORDS_C = 32'(MEM_WORDS);

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             faulted_q, faulted_d;

  logic [31:0] pc_mem_q  [DEPTH];
  logic [31:0] ins_mem_q [DEPTH];

  logic not_empty;
  logic pop;
  logic in_range;
  logic space;
  logic fire;
  logic fault_set;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign not_empty    = (count_q != '0);
  assign bus.imemAddr = {2'b00, pc_q[31:2]};

  // A redirect cycle never completes a handshake: the head is about to be flushed.
  assign bus.outValid   = not_empty && !bus.redirectValid;
  assign bus.outPc      = not_empty ? pc_mem_q[head_q]  : '0;
  assign bus.outInstr   = not_empty ? ins_mem_q[head_q] : '0;
  assign bus.fetchFault = faulted_q;

  assign pop       = bus.outValid && bus.outReady;
  assign in_range  = ({2'b00, pc_q[31:2]} < MEM_WORDS_C);
  // A pop this cycle frees the slot the push needs, giving 1 instr/cycle when full.
  assign space     = (count_q < DEPTH_C) || pop;
  assign fire      = !bus.redirectValid && !faulted_q &&  in_range && space;
  assign fault_set = !bus.redirectValid && !faulted_q && !in_range && space;

  always_comb begin
    pc_d      = pc_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    faulted_d = faulted_q;
    if (bus.redirectValid) begin
      pc_d      = {bus.redirectTarget[31:2], 2'b00};
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      faulted_d = 1'b0;
    end else begin
      if (fire) begin
        pc_d   = pc_q + 32'd4;
        tail_d = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      if (fault_set) begin
        faulted_d = 1'b1;
      end
      if (fire && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !fire) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= {RESET_PC[31:2], 2'b00};
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      faulted_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else begin
      pc_q      <= pc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      faulted_q <= faulted_d;
      if (fire) begin
        pc_mem_q[tail_q]  <= pc_q;
        ins_mem_q[tail_q] <= bus.imemData;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random ready/redirect traffic vs a queue-based model.
// Outputs sampled 2 time units after the falling edge; model advances once per rising edge.
// Instruction memory is modelled as word i -> 32'hA000_0000 + i.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          DEPTH     = 2;
  localparam int          MEM_WORDS = 16384;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic clk;
  logic rst_n;
  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .MEM_WORDS(MEM_WORDS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.imemData = 32'hA000_0000 + bus.imemAddr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  entry_t      q[$];
  logic [31:0] m_pc;
  logic        m_faulted;

  function automatic logic [31:0] mem_word(input logic [31:0] byte_pc);
    return 32'hA000_0000 + (byte_pc >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc      = RESET_PC;
    m_faulted = 1'b0;
  endtask

  task automatic check_outs(input logic rv);
    logic        exp_vld;
    logic [31:0] exp_pc;
    logic [31:0] exp_ins;
    exp_vld = (q.size() != 0) && !rv;
    exp_pc  = (q.size() != 0) ? q[0].pc    : 32'h0;
    exp_ins = (q.size() != 0) ? q[0].instr : 32'h0;
    chk("outValid",   {31'b0, bus.outValid},   {31'b0, exp_vld});
    chk("outPc",      bus.outPc,               exp_pc);
    chk("outInstr",   bus.outInstr,            exp_ins);
    chk("fetchFault", {31'b0, bus.fetchFault}, {31'b0, m_faulted});
    chk("imemAddr",   bus.imemAddr,            m_pc >> 2);
  endtask

  // One clock cycle: drive, check, advance model across the rising edge.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] tgt);
    logic pop;
    bus.outReady       = rdy;
    bus.redirectValid  = rv;
    bus.redirectTarget = tgt;
    #2;
    check_outs(rv);
    pop = (q.size() != 0) && !rv && rdy;
    if (rv) begin
      q.delete();
      m_pc      = tgt & 32'hFFFF_FFFC;
      m_faulted = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (!m_faulted && q.size() < DEPTH) begin
        if ((m_pc >> 2) < MEM_WORDS) begin
          q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
          m_pc = m_pc + 32'd4;
        end else begin
          m_faulted = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic async_reset();
    bus.redirectValid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs(1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] tgt;
    rst_n              = 1'b0;
    bus.outReady       = 1'b0;
    bus.redirectValid  = 1'b0;
    bus.redirectTarget = 32'h0;
    model_reset();

    // Reset state.
    @(negedge clk);
    #2;
    check_outs(1'b0);
    rst_n = 1'b1;

    // Streaming with decode always ready.
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // Backpressure: fill, hold, then drain in order.
    repeat (5) step(1'b0, 1'b0, 32'h0);
    repeat (4) step(1'b1, 1'b0, 32'h0);

    // Redirect while full; low target bits dropped.
    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0103);
    repeat (4) step(1'b1, 1'b0, 32'h0);

    // Full FIFO with simultaneous push/pop.
    repeat (3) step(1'b0, 1'b0, 32'h0);
    repeat (4) step(1'b1, 1'b0, 32'h0);

    // Fetch off the end of instruction memory, then recover.
    step(1'b1, 1'b1, 32'h0000_FFFC);
    repeat (6) step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0000);
    repeat (4) step(1'b1, 1'b0, 32'h0);

    // Asynchronous reset with buffered entries.
    repeat (3) step(1'b0, 1'b0, 32'h0);
    async_reset();
    repeat (4) step(1'b1, 1'b0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       tgt = $urandom & 32'h0000_FFFF;
        1:       tgt = 32'h0000_FFE0 + 32'($urandom_range(0, 31));
        2:       tgt = $urandom;
        default: tgt = 32'h0;
      endcase
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
